shape_metric_div: RTL

Parametrised blob shape-metric unit that replaces the single-mode circularity stage. It accepts one blob's area, perimeter and bounding box over a valid/ready handshake and computes one of two metrics, each scaled to 0..100 for an ideal shape. The division is an internal radix-2 restoring divider. The unit flags divide-by-zero and saturation, and passes a blob tag through so downstream logic can match results to blobs. It sits between the blob-statistics accumulator and the classifier.

---
 rtl/shape_metric_div_if.sv | 48 ++++
 rtl/shape_metric_div.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/shape_metric_div_if.sv
// rtl/shape_metric_div_if.sv - request/result bundle for the blob shape-metric divider
//
// Purpose: groups the request handshake (blob operands, mode, tag) and the
// result handshake (score, tag, flags) of shape_metric_div.
// Signals:
//   area_in, perimeter_in, bbox_w_in, bbox_h_in  blob operands (AW bits)
//   mode_in       0 = circularity, 1 = extent
//   tag_in        blob identifier carried to tag_out
//   in_valid_in / in_ready_out    request handshake
//   score_out, tag_out, err_out, sat_out          result payload
//   out_valid_out / out_ready_in  result handshake
//   busy_out      unit is not idle
// master: request producer / result consumer. slave: the divider.
interface shape_metric_div_if #(
  parameter int AW    = 17,
  parameter int OUT_W = 8,
  parameter int TAG_W = 4
);
  logic [AW-1:0]    area_in;
  logic [AW-1:0]    perimeter_in;
  logic [AW-1:0]    bbox_w_in;
  logic [AW-1:0]    bbox_h_in;
  logic             mode_in;
  logic [TAG_W-1:0] tag_in;
  logic             in_valid_in;
  logic             in_ready_out;
  logic [OUT_W-1:0] score_out;
  logic [TAG_W-1:0] tag_out;
  logic             err_out;
  logic             sat_out;
  logic             out_valid_out;
  logic             out_ready_in;
  logic             busy_out;

  modport master (
    output area_in, perimeter_in, bbox_w_in, bbox_h_in, mode_in, tag_in,
    output in_valid_in, out_ready_in,
    input  in_ready_out, score_out, tag_out, err_out, sat_out,
    input  out_valid_out, busy_out
  );

  modport slave (
    input  area_in, perimeter_in, bbox_w_in, bbox_h_in, mode_in, tag_in,
    input  in_valid_in, out_ready_in,
    output in_ready_out, score_out, tag_out, err_out, sat_out,
    output out_valid_out, busy_out
  );
endinterface

// File: rtl/shape_metric_div.sv
// rtl/shape_metric_div.sv - blob circularity/extent score via radix-2 restoring divider
//
// Purpose: takes one blob's area, perimeter and bounding box, forms
//   mode 0 (circularity): N = 1256*area, D = perimeter^2
//   mode 1 (extent):      N = 100*area,  D = bbox_w*bbox_h
// and returns floor(N/D) clamped to 2**OUT_W-1, with divide-by-zero and
// saturation flags and the request tag.
// Ports:
//   clk_in    clock, rising edge
//   rst_n_in  synchronous active-low reset
//   bus       shape_metric_div_if.slave (request and result handshakes)
module shape_metric_div #(
  parameter int WIDTH  = 180,
  parameter int HEIGHT = 320,
  parameter int AW     = $clog2(WIDTH*HEIGHT)+1,
  parameter int OUT_W  = 8,
  parameter int TAG_W  = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  shape_metric_div_if.slave bus
);

  localparam int NUM_W   = AW + 11;
  localparam int DW      = 2 * AW;
  localparam int CW      = $clog2(NUM_W);
  localparam int SAT_MAX = (2 ** OUT_W) - 1;

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t state, state_next;

  logic [AW-1:0]    area_r, perim_r, bw_r, bh_r;
  logic             mode_r;
  logic [TAG_W-1:0] tag_r;
  logic [NUM_W-1:0] num_r;     // numerator, shifted out MSB first
  logic [DW-1:0]    den_r;
  logic [DW-1:0]    rem_r;     // always < den_r between steps
  logic [NUM_W-2:0] quo_r;     // quotient bits collected so far
  logic [CW-1:0]    cnt_r;
  logic [OUT_W-1:0] score_r;
  logic             err_r, sat_r;

  logic [NUM_W-1:0] n_calc;
  logic [DW-1:0]    d_calc;
  logic [DW:0]      rem_shift;
  logic             rem_ge;
  logic [DW-1:0]    rem_next;
  logic [NUM_W-1:0] quo_next;
  logic             last_bit;

  // Operand products are formed at full width so nothing is truncated.
  always_comb begin
    n_calc = '0;
    d_calc = '0;
    if (mode_r) begin
      n_calc = NUM_W'(area_r) * NUM_W'(100);
      d_calc = DW'(bw_r) * DW'(bh_r);
    end else begin
      n_calc = NUM_W'(area_r) * NUM_W'(1256);
      d_calc = DW'(perim_r) * DW'(perim_r);
    end
  end

  // One restoring step. The shifted remainder needs one extra bit; after a
  // subtraction the result is below den_r, so DW bits hold it exactly.
  always_comb begin
    rem_shift = {rem_r, num_r[NUM_W-1]};
    rem_ge    = (rem_shift >= {1'b0, den_r});
    rem_next  = rem_ge ? (rem_shift[DW-1:0] - den_r) : rem_shift[DW-1:0];
    quo_next  = {quo_r, rem_ge};
    last_bit  = (cnt_r == CW'(NUM_W-1));
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid_in) state_next = LOAD;
      LOAD: state_next = (d_calc == '0) ? DONE : DIV;
      DIV:  if (last_bit) state_next = DONE;
      DONE: if (bus.out_ready_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      area_r  <= '0;
      perim_r <= '0;
      bw_r    <= '0;
      bh_r    <= '0;
      mode_r  <= 1'b0;
      tag_r   <= '0;
      num_r   <= '0;
      den_r   <= '0;
      rem_r   <= '0;
      quo_r   <= '0;
      cnt_r   <= '0;
      score_r <= '0;
      err_r   <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid_in) begin
            area_r  <= bus.area_in;
            perim_r <= bus.perimeter_in;
            bw_r    <= bus.bbox_w_in;
            bh_r    <= bus.bbox_h_in;
            mode_r  <= bus.mode_in;
            tag_r   <= bus.tag_in;
          end
        end
        LOAD: begin
          num_r <= n_calc;
          den_r <= d_calc;
          rem_r <= '0;
          quo_r <= '0;
          cnt_r <= '0;
          if (d_calc == '0) begin
            score_r <= '0;
            err_r   <= 1'b1;
            sat_r   <= 1'b0;
          end
        end
        DIV: begin
          num_r <= num_r << 1;
          rem_r <= rem_next;
          quo_r <= quo_next[NUM_W-2:0];
          cnt_r <= cnt_r + CW'(1);
          if (last_bit) begin
            err_r <= 1'b0;
            if (quo_next > NUM_W'(SAT_MAX)) begin
              score_r <= OUT_W'(SAT_MAX);
              sat_r   <= 1'b1;
            end else begin
              score_r <= quo_next[OUT_W-1:0];
              sat_r   <= 1'b0;
            end
          end
        end
        DONE: begin
          // Payload only changes once the result has been taken.
          if (bus.out_ready_in) begin
            score_r <= '0;
            err_r   <= 1'b0;
            sat_r   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready_out  = (state == IDLE);
  assign bus.busy_out      = (state != IDLE);
  assign bus.out_valid_out = (state == DONE);
  assign bus.score_out     = score_r;
  assign bus.tag_out       = tag_r;
  assign bus.err_out       = err_r;
  assign bus.sat_out       = sat_r;

endmodule
